// File: rtl/if_stage_if.sv
// Instruction-memory request/ready port between the fetch stage (master) and memory (slave).
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem request/ready port, IF/ID register, redirects and stalls.
// Optional macro IF_FLUSH_ON_REDIRECT_EN squashes the delay-slot word on a redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        if_pc_source,
  input  logic [31:0]       branch_addr,
  input  logic [31:0]       jump_addr,
  input  logic              hazard,
  input  logic              pstop_i,
  if_stage_if.master        imem,
  output logic [31:0]       pc,
  output logic [31:0]       IF_ID_instruction,
  output logic [31:0]       IF_ID_next_i_addr
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state_q;
  logic [31:0] pc_q;
  logic [31:0] ibuf_q;
  logic        pending_q;
  logic [31:0] pending_tgt_q;
  logic [31:0] instr_q;
  logic [31:0] next_addr_q;

  logic        adv;
  logic        have;
  logic        redir;
  logic        squash;
  logic [31:0] word;
  logic [31:0] tgt;
  logic [31:0] pc_plus4;

  assign adv      = !hazard && !pstop_i;
  assign have     = ((state_q == FETCH) && imem.imem_ready) || (state_q == HOLD);
  assign word     = (state_q == HOLD) ? ibuf_q : imem.imem_rdata;
  assign redir    = adv && ((if_pc_source == 2'd1) || (if_pc_source == 2'd2));
  assign tgt      = (if_pc_source == 2'd2) ? jump_addr : branch_addr;
  assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_FLUSH_ON_REDIRECT_EN
  assign squash = redir || pending_q;
`else
  assign squash = 1'b0;
`endif

  assign imem.imem_req   = !rst && (state_q == FETCH);
  assign imem.imem_addr  = pc_q;
  assign pc                = pc_q;
  assign IF_ID_instruction = instr_q;
  assign IF_ID_next_i_addr = next_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      ibuf_q        <= 32'd0;
      pending_q     <= 1'b0;
      pending_tgt_q <= 32'd0;
      instr_q       <= 32'd0;
      next_addr_q   <= 32'd0;
    end else if (adv && have) begin
      instr_q     <= squash ? 32'd0 : word;
      next_addr_q <= pc_plus4;
      state_q     <= FETCH;
      pending_q   <= 1'b0;
      if (pending_q) begin
        pc_q <= pending_tgt_q;
      end else if (redir) begin
        pc_q <= tgt;
      end else begin
        pc_q <= pc_plus4;
      end
    end else if (adv) begin
      // Memory is slow: bubble decode and remember any redirect until the fetch lands.
      instr_q <= 32'd0;
      if (redir && !pending_q) begin
        pending_q     <= 1'b1;
        pending_tgt_q <= tgt;
      end
    end else if ((state_q == FETCH) && imem.imem_ready) begin
      ibuf_q  <= imem.imem_rdata;
      state_q <= HOLD;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; memory returns {16'hC0DE, addr[15:0]}.
module tb_if_stage;
  logic        clk;
  logic        rst;
  logic [1:0]  if_pc_source;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic        hazard;
  logic        pstop_i;
  logic [31:0] pc;
  logic [31:0] IF_ID_instruction;
  logic [31:0] IF_ID_next_i_addr;
  int          checks;
  int          errors;
  logic [31:0] exp_slot;

  if_stage_if bus ();

  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};

  if_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_pc_source      (if_pc_source),
    .branch_addr       (branch_addr),
    .jump_addr         (jump_addr),
    .hazard            (hazard),
    .pstop_i           (pstop_i),
    .imem              (bus.master),
    .pc                (pc),
    .IF_ID_instruction (IF_ID_instruction),
    .IF_ID_next_i_addr (IF_ID_next_i_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.imem_ready = 1'b1; hazard = 1'b0; pstop_i = 1'b0;
    if_pc_source = 2'd0; branch_addr = 32'd0; jump_addr = 32'd0;
    step(); step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL reset_req: got %0b want 0", bus.imem_req); end
    checks++; if (IF_ID_instruction !== 32'd0) begin errors++;
      $display("FAIL reset_instr: got %h want 0", IF_ID_instruction); end
    checks++; if (IF_ID_next_i_addr !== 32'd0) begin errors++;
      $display("FAIL reset_next: got %h want 0", IF_ID_next_i_addr); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++;
      $display("FAIL first_fetch: req %0b addr %h want 1 100", bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (bus.imem_addr !== 32'h104 || IF_ID_next_i_addr !== 32'h104) begin errors++;
      $display("FAIL seq1: addr %h next %h want 104 104", bus.imem_addr, IF_ID_next_i_addr); end
    step();
    checks++; if (bus.imem_addr !== 32'h108 || IF_ID_next_i_addr !== 32'h108 ||
                  IF_ID_instruction !== 32'hC0DE_0104) begin errors++;
      $display("FAIL seq2: addr %h next %h instr %h want 108 108 c0de0104",
               bus.imem_addr, IF_ID_next_i_addr, IF_ID_instruction); end
  endtask

  task automatic test_wait_states();
    // Branch to 0x20 first so the slow fetch happens there.
    if_pc_source = 2'd1; branch_addr = 32'h20;
    step();
    checks++; if (pc !== 32'h20) begin errors++;
      $display("FAIL redirect_to_20: got %h want 20", pc); end
    if_pc_source = 2'd0; bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (IF_ID_instruction !== 32'd0 || bus.imem_addr !== 32'h20 ||
                    IF_ID_next_i_addr !== 32'h10C || bus.imem_req !== 1'b1) begin errors++;
        $display("FAIL bubble%0d: instr %h addr %h next %h req %0b want 0 20 10c 1",
                 i, IF_ID_instruction, bus.imem_addr, IF_ID_next_i_addr, bus.imem_req); end
    end
    bus.imem_ready = 1'b1;
    step();
    checks++; if (IF_ID_instruction !== 32'hC0DE_0020 || IF_ID_next_i_addr !== 32'h24 ||
                  pc !== 32'h24) begin errors++;
      $display("FAIL wait_deliver: instr %h next %h pc %h want c0de0020 24 24",
               IF_ID_instruction, IF_ID_next_i_addr, pc); end
  endtask

  task automatic test_hazard();
    hazard = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0 || IF_ID_instruction !== 32'hC0DE_0020 ||
                  pc !== 32'h24) begin errors++;
      $display("FAIL hold1: req %0b instr %h pc %h want 0 c0de0020 24",
               bus.imem_req, IF_ID_instruction, pc); end
    step();
    checks++; if (bus.imem_req !== 1'b0 || IF_ID_next_i_addr !== 32'h24) begin errors++;
      $display("FAIL hold2: req %0b next %h want 0 24", bus.imem_req, IF_ID_next_i_addr); end
    hazard = 1'b0;
    step();
    checks++; if (IF_ID_instruction !== 32'hC0DE_0024 || IF_ID_next_i_addr !== 32'h28 ||
                  bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h28) begin errors++;
      $display("FAIL hold_release: instr %h next %h req %0b addr %h want c0de0024 28 1 28",
               IF_ID_instruction, IF_ID_next_i_addr, bus.imem_req, bus.imem_addr); end
    // pstop with an outstanding request: everything holds, request stays up.
    pstop_i = 1'b1; bus.imem_ready = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h28 ||
                  IF_ID_instruction !== 32'hC0DE_0024) begin errors++;
      $display("FAIL pstop_hold: req %0b addr %h instr %h want 1 28 c0de0024",
               bus.imem_req, bus.imem_addr, IF_ID_instruction); end
    pstop_i = 1'b0; bus.imem_ready = 1'b1;
    step();
    checks++; if (IF_ID_instruction !== 32'hC0DE_0028 || pc !== 32'h2C) begin errors++;
      $display("FAIL pstop_release: instr %h pc %h want c0de0028 2c", IF_ID_instruction, pc); end
  endtask

  task automatic test_branch();
`ifdef IF_FLUSH_ON_REDIRECT_EN
    exp_slot = 32'd0;
`else
    exp_slot = 32'hC0DE_002C;
`endif
    if_pc_source = 2'd1; branch_addr = 32'h400;
    step();
    checks++; if (IF_ID_instruction !== exp_slot || IF_ID_next_i_addr !== 32'h30 ||
                  bus.imem_addr !== 32'h400) begin errors++;
      $display("FAIL branch_slot: instr %h next %h addr %h want %h 30 400",
               IF_ID_instruction, IF_ID_next_i_addr, bus.imem_addr, exp_slot); end
    if_pc_source = 2'd0;
    step();
    checks++; if (IF_ID_instruction !== 32'hC0DE_0400 || pc !== 32'h404) begin errors++;
      $display("FAIL branch_target: instr %h pc %h want c0de0400 404", IF_ID_instruction, pc); end
  endtask

  task automatic test_jump_pending();
`ifdef IF_FLUSH_ON_REDIRECT_EN
    exp_slot = 32'd0;
`else
    exp_slot = 32'hC0DE_0404;
`endif
    bus.imem_ready = 1'b0; if_pc_source = 2'd2; jump_addr = 32'h800;
    step();
    checks++; if (dut.pending_q !== 1'b1 || bus.imem_addr !== 32'h404 ||
                  IF_ID_instruction !== 32'd0) begin errors++;
      $display("FAIL jump_pending: pending %0b addr %h instr %h want 1 404 0",
               dut.pending_q, bus.imem_addr, IF_ID_instruction); end
    // A second redirect while one is pending must not replace it.
    if_pc_source = 2'd1; branch_addr = 32'h999; jump_addr = 32'hDEAD;
    step();
    checks++; if (bus.imem_addr !== 32'h404 || bus.imem_req !== 1'b1) begin errors++;
      $display("FAIL pending_wait: addr %h req %0b want 404 1", bus.imem_addr, bus.imem_req); end
    if_pc_source = 2'd0; bus.imem_ready = 1'b1;
    step();
    checks++; if (pc !== 32'h800 || IF_ID_instruction !== exp_slot ||
                  IF_ID_next_i_addr !== 32'h408 || dut.pending_q !== 1'b0) begin errors++;
      $display("FAIL pending_apply: pc %h instr %h next %h pending %0b want 800 %h 408 0",
               pc, IF_ID_instruction, IF_ID_next_i_addr, dut.pending_q, exp_slot); end
  endtask

  task automatic test_wrap();
    if_pc_source = 2'd2; jump_addr = 32'hFFFF_FFFC;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_jump: pc %h want fffffffc", pc); end
    if_pc_source = 2'd0;
    step();
    checks++; if (pc !== 32'd0 || IF_ID_next_i_addr !== 32'd0 ||
                  IF_ID_instruction !== 32'hC0DE_FFFC) begin errors++;
      $display("FAIL wrap_seq: pc %h next %h instr %h want 0 0 c0defffc",
               pc, IF_ID_next_i_addr, IF_ID_instruction); end
    step();
    checks++; if (bus.imem_addr !== 32'h4) begin errors++;
      $display("FAIL wrap_next: addr %h want 4", bus.imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    bus.imem_ready = 1'b0;
    step();
    rst = 1'b1; bus.imem_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++;
      $display("FAIL midreset_req: got %0b want 0", bus.imem_req); end
    step();
    checks++; if (pc !== 32'h100 || IF_ID_instruction !== 32'd0 ||
                  IF_ID_next_i_addr !== 32'd0) begin errors++;
      $display("FAIL midreset_state: pc %h instr %h next %h want 100 0 0",
               pc, IF_ID_instruction, IF_ID_next_i_addr); end
    rst = 1'b0;
    step();
    checks++; if (IF_ID_instruction !== 32'hC0DE_0100 || pc !== 32'h104) begin errors++;
      $display("FAIL midreset_resume: instr %h pc %h want c0de0100 104", IF_ID_instruction, pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_wait_states();
    test_hazard();
    test_branch();
    test_jump_pending();
    test_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
